seq_detector_prog: RTL and testbench

Parametrised serial pattern detector. It is the runtime-programmable successor to the fixed Moore sequence detectors in the FSM library. It matches a PAT_W-bit pattern, with per-bit don't-care masking, against a 1-bit serial stream. Overlapping or non-overlapping mode is selectable at runtime. The block produces a registered (Moore) detect pulse and a saturating hit counter.

---
 rtl/seq_detector_prog.sv | 86 ++++++++
 tb/tb_seq_detector_prog.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with per-bit care mask,
// selectable overlap mode, registered detect pulse and a saturating hit counter.
module seq_detector_prog #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             ovl_in,
    input  logic             en,
    input  logic             data_in,
    input  logic             clr_cnt,
    output logic             data_out,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [PAT_W-1:0] cfg_pat
);

    localparam int unsigned    FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic             match;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift history, advance fill (EMPTY/PARTIAL/PRIMED), detect and count.
    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        match    = 1'b0;
        cnt_d    = cnt_q;
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + FW'(1);

        if (cfg_we) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = {hist_q[PAT_W-2:0], data_in};
            fill_d = fill_inc;
            match  = (fill_inc == FULL) && (&((hist_d ~^ pat_q) | ~mask_q));
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            if (match && !ovl_q) begin
                fill_d = '0;
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and configuration registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q    <= '0;
            mask_q   <= '1;
            ovl_q    <= 1'b1;
            hist_q   <= '0;
            fill_q   <= '0;
            data_out <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (cfg_we) begin
                pat_q  <= pat_in;
                mask_q <= mask_in;
                ovl_q  <= ovl_in;
            end
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            data_out <= match;
            cnt_q    <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
    assign cfg_pat = pat_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog (default and 2-bit counter builds).
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, ovl_in, en, data_in, clr_cnt;
    logic [3:0] pat_in, mask_in;
    logic       data_out, data_out_c2;
    logic [7:0] hit_cnt;
    logic [1:0] hit_cnt_c2;
    logic [3:0] cfg_pat, cfg_pat_c2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .pat_in(pat_in), .mask_in(mask_in),
        .ovl_in(ovl_in), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .data_out(data_out), .hit_cnt(hit_cnt), .cfg_pat(cfg_pat)
    );

    seq_detector_prog #(.PAT_W(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .pat_in(pat_in), .mask_in(mask_in),
        .ovl_in(ovl_in), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .data_out(data_out_c2), .hit_cnt(hit_cnt_c2), .cfg_pat(cfg_pat_c2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Config edge with en=1/data=1 to show en is ignored there.
    task automatic cfg(input logic [3:0] p, input logic [3:0] m, input logic o);
        cfg_we = 1'b1; pat_in = p; mask_in = m; ovl_in = o; en = 1'b1; data_in = 1'b1;
        tick();
        cfg_we = 1'b0; en = 1'b0;
        check("cfg_pat", 32'(cfg_pat), 32'(p));
        check("cfg_dout", 32'(data_out), 0);
    endtask

    task automatic clr();
        clr_cnt = 1'b1; en = 1'b0;
        tick();
        clr_cnt = 1'b0;
        check("clr_hit", 32'(hit_cnt), 0);
    endtask

    task automatic stream(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] exp);
        logic b, e;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            e = exp[n-1-i];
            en = 1'b1; data_in = b;
            tick();
            check($sformatf("%s[%0d]", tag, i), 32'(data_out), 32'(e));
        end
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; pat_in = '0; mask_in = '0; ovl_in = 1'b0;
        en = 1'b0; data_in = 1'b0; clr_cnt = 1'b0;
        tick(); tick();
        check("rst_dout", 32'(data_out), 0);
        check("rst_hit", 32'(hit_cnt), 0);
        check("rst_pat", 32'(cfg_pat), 0);
        rst_n = 1'b1;

        // 1: overlapping exact match
        cfg(4'b1001, 4'hF, 1'b1);
        stream("t1", 16'b1001001, 7, 16'b0001001);
        check("t1_hit", 32'(hit_cnt), 2);

        // 2: non-overlapping
        cfg(4'b1001, 4'hF, 1'b0);
        clr();
        stream("t2", 16'b1001001, 7, 16'b0001000);
        check("t2_hit", 32'(hit_cnt), 1);

        // 3: masked middle bits, overlapping
        cfg(4'b1001, 4'b1001, 1'b1);
        clr();
        stream("t3", 16'b111111, 6, 16'b000111);
        check("t3_hit", 32'(hit_cnt), 3);

        // 4: en gaps hold history
        cfg(4'b1001, 4'hF, 1'b1);
        clr();
        stream("t4a", 16'b100, 3, 16'b000);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; data_in = 1'b1;
            tick();
            check("t4_gap", 32'(data_out), 0);
        end
        stream("t4b", 16'b1, 1, 16'b1);
        check("t4_hit", 32'(hit_cnt), 1);

        // 5: saturation of the 2-bit counter, clr wins over match
        cfg(4'b1001, 4'b1001, 1'b1);
        clr();
        stream("t5", 16'b11111111, 8, 16'b00011111);
        check("t5_hit", 32'(hit_cnt), 5);
        check("t5_sat", 32'(hit_cnt_c2), 3);
        stream("t5b", 16'b1, 1, 16'b1);
        check("t5_hold", 32'(hit_cnt_c2), 3);
        check("t5_hit6", 32'(hit_cnt), 6);
        en = 1'b1; data_in = 1'b1; clr_cnt = 1'b1;
        tick();
        en = 1'b0; clr_cnt = 1'b0;
        check("t5_clr_dout", 32'(data_out), 1);
        check("t5_clr_hit", 32'(hit_cnt), 0);
        check("t5_clr_c2", 32'(hit_cnt_c2), 0);

        // 6a: reset mid-stream discards history and config
        cfg(4'b1001, 4'hF, 1'b1);
        stream("t6a", 16'b1001, 4, 16'b0001);
        rst_n = 1'b0; en = 1'b1; data_in = 1'b1;
        tick();
        rst_n = 1'b1; en = 1'b0;
        check("t6_rst_dout", 32'(data_out), 0);
        check("t6_rst_hit", 32'(hit_cnt), 0);
        check("t6_rst_pat", 32'(cfg_pat), 0);
        stream("t6b", 16'b0000, 4, 16'b0001);

        // 6b: cfg mid-stream clears history; en ignored on the cfg edge
        cfg(4'b1001, 4'hF, 1'b1);
        stream("t6c", 16'b100, 3, 16'b000);
        cfg(4'b1001, 4'hF, 1'b1);
        stream("t6d", 16'b001001, 6, 16'b000001);

        // all-zero mask matches every primed sample
        cfg(4'b0000, 4'b0000, 1'b1);
        stream("t7", 16'b10110, 5, 16'b00011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
